sky130_sram_rw_port_ctrl: RTL and testbench

//  Upstream driver for port 0 (RW) of the 2048x32 single-clock SRAM macro.
//  - Accepts word requests from the core bus and converts them into macro csb0/web0/addr0/din0 cycles.
//  - Returns read data captured from dout0.
//  - The macro has no write mask, so partial writes are done as read-modify-write.
//  - Port 1 of the macro is not driven by this block.

---
 rtl/sky130_sram_rw_port_ctrl_pkg.sv | 18 +
 rtl/sky130_sram_rw_port_ctrl_if.sv | 26 ++
 rtl/sky130_sram_rw_port_ctrl_byte_merge.sv | 17 +
 rtl/sky130_sram_rw_port_ctrl.sv | 138 +++++++++++++
 tb/tb_sky130_sram_rw_port_ctrl.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/sky130_sram_rw_port_ctrl_pkg.sv
// rtl/sky130_sram_rw_port_ctrl_pkg.sv - shared types and sizes for the SRAM port-0 controller
package sram_ctrl_pkg;

   localparam int         SRAM_DW     = 32;
   localparam int         SRAM_AW     = 11;
   localparam int         SRAM_NBYTES = 4;
   localparam logic [3:0] BE_FULL     = 4'hF;

   typedef enum logic [2:0] {
      IDLE,
      RD,
      RD_WAIT,
      RMW_RD,
      RMW_WAIT,
      WR
   } state_e;

endpackage

// File: rtl/sky130_sram_rw_port_ctrl_if.sv
// rtl/sky130_sram_rw_port_ctrl_if.sv - core-side request/response bus of the SRAM port-0 controller
interface sram_req_if
   import sram_ctrl_pkg::*;
#(
   parameter int AW = SRAM_AW,
   parameter int DW = SRAM_DW
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [AW-1:0]     req_addr;
   logic [DW-1:0]     req_wdata;
   logic [DW/8-1:0]   req_be;
   logic              rsp_valid;
   logic [DW-1:0]     rsp_rdata;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_be,
      input  req_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_be,
      output req_ready, rsp_valid, rsp_rdata
   );
endinterface

// File: rtl/sky130_sram_rw_port_ctrl_byte_merge.sv
// rtl/sky130_sram_rw_port_ctrl_byte_merge.sv - per-lane select between old word and new write data
module sram_byte_merge
   import sram_ctrl_pkg::*;
#(
   parameter int NBYTES = SRAM_NBYTES
) (
   input  logic [8*NBYTES-1:0] old_i,
   input  logic [8*NBYTES-1:0] new_i,
   input  logic [NBYTES-1:0]   be_i,
   output logic [8*NBYTES-1:0] merged_o
);

   for (genvar i = 0; i < NBYTES; i++) begin : g_lane
      assign merged_o[8*i +: 8] = be_i[i] ? new_i[8*i +: 8] : old_i[8*i +: 8];
   end

endmodule

// File: rtl/sky130_sram_rw_port_ctrl.sv
// rtl/sky130_sram_rw_port_ctrl.sv - port-0 (RW) driver for the 2048x32 single-clock SRAM macro
// Converts word requests into registered csb0/web0/addr0/din0 cycles; partial writes use RMW.
module sky130_sram_rw_port_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = SRAM_DW,
   parameter int ADDR_WIDTH = SRAM_AW
) (
   input  logic                  clk,
   input  logic                  rst_n,
   sram_req_if.slave             bus,
   output logic                  sram_csb0,
   output logic                  sram_web0,
   output logic [ADDR_WIDTH-1:0] sram_addr0,
   output logic [DATA_WIDTH-1:0] sram_din0,
   input  logic [DATA_WIDTH-1:0] sram_dout0
);

   localparam int NB = DATA_WIDTH / 8;

   state_e                  state_q, state_d;
   logic                    csb_q, csb_d;
   logic                    web_q, web_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   din_q, din_d;
   logic                    rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [NB-1:0]           be_q, be_d;
   logic                    req_ready;
   logic [DATA_WIDTH-1:0]   merged;

   sram_byte_merge #(
      .NBYTES (NB)
   ) u_merge (
      .old_i    (sram_dout0),
      .new_i    (wdata_q),
      .be_i     (be_q),
      .merged_o (merged)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         csb_q       <= 1'b1;
         web_q       <= 1'b1;
         addr_q      <= '0;
         din_q       <= '0;
         rsp_valid_q <= 1'b0;
         rdata_q     <= '0;
         wdata_q     <= '0;
         be_q        <= '0;
      end else begin
         state_q     <= state_d;
         csb_q       <= csb_d;
         web_q       <= web_d;
         addr_q      <= addr_d;
         din_q       <= din_d;
         rsp_valid_q <= rsp_valid_d;
         rdata_q     <= rdata_d;
         wdata_q     <= wdata_d;
         be_q        <= be_d;
      end
   end

   // Macro outputs are registered, so each state sets up the command for the next state.
   always_comb begin
      state_d     = state_q;
      csb_d       = 1'b1;
      web_d       = 1'b1;
      addr_d      = addr_q;
      din_d       = din_q;
      rsp_valid_d = 1'b0;
      rdata_d     = rdata_q;
      wdata_d     = wdata_q;
      be_d        = be_q;
      req_ready   = 1'b0;

      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (bus.req_valid) begin
               addr_d  = bus.req_addr;
               wdata_d = bus.req_wdata;
               be_d    = bus.req_be;
               if (!bus.req_we) begin
                  state_d = RD;
                  csb_d   = 1'b0;
               end else if (&bus.req_be) begin
                  state_d = WR;
                  csb_d   = 1'b0;
                  web_d   = 1'b0;
                  din_d   = bus.req_wdata;
               end else if (|bus.req_be) begin
                  state_d = RMW_RD;
                  csb_d   = 1'b0;
               end else begin
                  rsp_valid_d = 1'b1;
               end
            end
         end
         RD: begin
            state_d = RD_WAIT;
         end
         RD_WAIT: begin
            rdata_d     = sram_dout0;
            rsp_valid_d = 1'b1;
            state_d     = IDLE;
         end
         RMW_RD: begin
            state_d = RMW_WAIT;
         end
         // dout0 is only valid up to this edge, so the merge is captured straight into din0.
         RMW_WAIT: begin
            csb_d   = 1'b0;
            web_d   = 1'b0;
            din_d   = merged;
            state_d = WR;
         end
         WR: begin
            rsp_valid_d = 1'b1;
            state_d     = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.req_ready = req_ready;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rdata_q;
   assign sram_csb0     = csb_q;
   assign sram_web0     = web_q;
   assign sram_addr0    = addr_q;
   assign sram_din0     = din_q;

endmodule

// File: tb/tb_sky130_sram_rw_port_ctrl.sv
// tb/tb_sky130_sram_rw_port_ctrl.sv - directed self-checking bench with a behavioural SRAM macro model
module tb_sky130_sram_rw_port_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        sram_csb0;
   logic        sram_web0;
   logic [10:0] sram_addr0;
   logic [31:0] sram_din0;
   logic [31:0] sram_dout0;

   sram_req_if bus ();

   sky130_sram_rw_port_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .sram_csb0  (sram_csb0),
      .sram_web0  (sram_web0),
      .sram_addr0 (sram_addr0),
      .sram_din0  (sram_din0),
      .sram_dout0 (sram_dout0)
   );

   always #5 clk = ~clk;

   // Macro model: command captured at posedge, write commits on the following negedge,
   // read data valid for one cycle only, garbage otherwise.
   logic [31:0] mem [0:2047];
   logic        wr_pend;
   logic [10:0] wr_addr;
   logic [31:0] wr_data;

   always @(posedge clk) begin
      wr_pend <= !sram_csb0 && !sram_web0;
      wr_addr <= sram_addr0;
      wr_data <= sram_din0;
      if (!sram_csb0 && sram_web0) sram_dout0 <= mem[sram_addr0];
      else                         sram_dout0 <= $urandom;
   end

   always @(negedge clk) begin
      if (wr_pend) mem[wr_addr] <= wr_data;
   end

   int       csb_lo_cnt = 0;
   int       rsp_cnt    = 0;
   logic [7:0] web_hist = '0;

   always @(negedge clk) begin
      if (!sram_csb0) begin
         csb_lo_cnt <= csb_lo_cnt + 1;
         web_hist   <= {web_hist[6:0], sram_web0};
      end
      if (bus.rsp_valid) rsp_cnt <= rsp_cnt + 1;
   end

   int n_cmp = 0;
   int n_mis = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Called #1 after a posedge; returns #1 after the edge at which rsp_valid is first seen.
   task automatic do_req(input logic we, input logic [10:0] a, input logic [31:0] d,
                         input logic [3:0] be, output int lat);
      int w;
      bus.req_valid = 1'b1;
      bus.req_we    = we;
      bus.req_addr  = a;
      bus.req_wdata = d;
      bus.req_be    = be;
      w = 0;
      while (!bus.req_ready && w < 20) begin
         @(posedge clk); #1; w++;
      end
      if (!bus.req_ready) chk("accept_timeout", 32'(bus.req_ready), 32'd1);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      lat = 1;
      while (!bus.rsp_valid && lat < 12) begin
         @(posedge clk); #1; lat++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int c0, r0;
      logic [7:0] h;

      rst_n         = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.req_be    = '0;

      // 1: reset
      repeat (3) @(posedge clk);
      #1;
      chk("rst_csb0",  32'(sram_csb0), 32'd1);
      chk("rst_web0",  32'(sram_web0), 32'd1);
      chk("rst_rspv",  32'(bus.rsp_valid), 32'd0);
      chk("rst_ready", 32'(bus.req_ready), 32'd1);
      chk("rst_addr0", 32'(sram_addr0), 32'd0);
      chk("rst_din0",  sram_din0, 32'd0);
      chk("rst_rdata", bus.rsp_rdata, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // preload through full writes
      do_req(1'b1, 11'h010, 32'h11223344, 4'hF, lat);
      do_req(1'b1, 11'h020, 32'h55555555, 4'hF, lat);
      do_req(1'b1, 11'h7FF, 32'h00000000, 4'hF, lat);
      do_req(1'b1, 11'h000, 32'h0BADF00D, 4'hF, lat);

      // 2: full write then read
      do_req(1'b1, 11'h123, 32'hDEADBEEF, 4'hF, lat);
      chk("fw_lat", 32'(lat), 32'd2);
      do_req(1'b0, 11'h123, 32'h0, 4'h0, lat);
      chk("rd_lat", 32'(lat), 32'd3);
      chk("rd_data", bus.rsp_rdata, 32'hDEADBEEF);
      @(posedge clk); #1;
      chk("rspv_one_cycle", 32'(bus.rsp_valid), 32'd0);

      // 3: partial write read-modify-write
      c0 = csb_lo_cnt;
      do_req(1'b1, 11'h010, 32'hAABBCCDD, 4'b0101, lat);
      chk("pw_lat", 32'(lat), 32'd4);
      chk("pw_rdata_held", bus.rsp_rdata, 32'hDEADBEEF);
      @(posedge clk); #1;
      h = web_hist;
      chk("pw_csb_cycles", 32'(csb_lo_cnt - c0), 32'd2);
      chk("pw_web_order", 32'(h[1:0]), 32'd2);
      do_req(1'b0, 11'h010, 32'h0, 4'h0, lat);
      chk("pw_readback", bus.rsp_rdata, 32'h11BB33DD);

      // 4: be=0 write
      @(posedge clk); #1;
      c0 = csb_lo_cnt;
      do_req(1'b1, 11'h7FF, 32'hFFFFFFFF, 4'h0, lat);
      chk("be0_lat", 32'(lat), 32'd1);
      chk("be0_rdata_held", bus.rsp_rdata, 32'h11BB33DD);
      @(posedge clk); #1;
      chk("be0_no_csb", 32'(csb_lo_cnt - c0), 32'd0);
      do_req(1'b0, 11'h7FF, 32'h0, 4'h0, lat);
      chk("be0_readback", bus.rsp_rdata, 32'h0);

      // 5: back-to-back reads with req_valid held
      repeat (2) @(posedge clk);
      #1;
      r0 = rsp_cnt;
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b0;
      bus.req_addr  = 11'h000;
      chk("b2b_ready0", 32'(bus.req_ready), 32'd1);
      @(posedge clk); #1;
      bus.req_addr = 11'h7FF;
      lat = 1;
      while (!bus.rsp_valid && lat < 12) begin
         @(posedge clk); #1; lat++;
      end
      chk("b2b_lat0", 32'(lat), 32'd3);
      chk("b2b_data0", bus.rsp_rdata, 32'h0BADF00D);
      chk("b2b_ready_in_rsp", 32'(bus.req_ready), 32'd1);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      lat = 1;
      while (!bus.rsp_valid && lat < 12) begin
         @(posedge clk); #1; lat++;
      end
      chk("b2b_lat1", 32'(lat), 32'd3);
      chk("b2b_data1", bus.rsp_rdata, 32'h0);
      repeat (3) @(posedge clk);
      #1;
      chk("b2b_rsp_count", 32'(rsp_cnt - r0), 32'd2);

      // 6: reset during RMW_WAIT
      r0 = rsp_cnt;
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_addr  = 11'h020;
      bus.req_wdata = 32'hAABBCCDD;
      bus.req_be    = 4'b0001;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("mid_rst_csb0", 32'(sram_csb0), 32'd1);
      chk("mid_rst_rspv", 32'(bus.rsp_valid), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("mid_rst_no_rsp", 32'(rsp_cnt - r0), 32'd0);
      do_req(1'b0, 11'h020, 32'h0, 4'h0, lat);
      chk("mid_rst_readback", bus.rsp_rdata, 32'h55555555);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
